// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fault;
   } fetch_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read straight from storage registers.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem_reg [DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [CW-1:0]  count_reg;
   logic           push_ok;
   logic           pop_ok;

   assign pop_ok  = pop && (count_reg != '0);
   assign push_ok = push && (count_reg != CW'(DEPTH) || pop_ok);

   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem_reg[wr_ptr_reg] <= push_entry;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
      end
   end

   assign head  = mem_reg[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the fetch PC, issues single-word reads and buffers returned words for decode.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic [31:0] i_imem_rdata,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc,
   output logic        o_instr_fault,
   input  logic        i_instr_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e  state_reg;
   logic [31:0]   fetch_pc_reg;
   logic [31:0]   req_pc_reg;
   logic          inflight_reg;
   logic          discard_reg;

   fetch_entry_t  head;
   fetch_entry_t  push_entry;
   logic [CW-1:0] count;
   logic          valid;
   logic          pop;
   logic          space;
   logic          aligned;
   logic          run;
   logic          issue;
   logic          accept;
   logic          resp_push;
   logic          fault_push;

   assign valid   = (count != '0);
   assign pop     = valid && i_instr_ready;
   // An in-flight response already owns a slot, so it is counted against free space.
   assign space   = (int'(count) + int'(inflight_reg) - int'(pop)) < FIFO_DEPTH;
   assign aligned = (fetch_pc_reg[1:0] == 2'b00);
   assign run     = i_rst_n && !i_redirect && (state_reg == RUN);
   assign issue   = run && aligned && space;
   assign accept  = issue && i_imem_gnt;

   assign resp_push  = inflight_reg && !discard_reg;
   // Waiting for inflight to drain keeps the fault entry behind all older data.
   assign fault_push = run && !aligned && !inflight_reg && space;

   always_comb begin
      push_entry = '{instr: i_imem_rdata, pc: req_pc_reg, fault: 1'b0};
      if (fault_push) begin
         push_entry = '{instr: NOP, pc: fetch_pc_reg, fault: 1'b1};
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .push       (resp_push || fault_push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (i_redirect),
      .head       (head),
      .count      (count)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg    <= RUN;
         fetch_pc_reg <= RESET_PC;
         req_pc_reg   <= '0;
         inflight_reg <= 1'b0;
         discard_reg  <= 1'b0;
      end else if (i_redirect) begin
         state_reg    <= RUN;
         fetch_pc_reg <= i_redirect_pc;
         inflight_reg <= accept;
         discard_reg  <= accept;
      end else begin
         inflight_reg <= accept;
         discard_reg  <= 1'b0;
         if (accept) begin
            fetch_pc_reg <= fetch_pc_reg + 32'd4;
            req_pc_reg   <= fetch_pc_reg;
         end
         if (fault_push) begin
            state_reg <= FAULT;
         end
      end
   end

   assign o_imem_req    = issue;
   assign o_imem_addr   = issue ? fetch_pc_reg : '0;
   assign o_instr_valid = valid;
   assign o_instr       = valid ? head.instr : '0;
   assign o_instr_pc    = valid ? head.pc : '0;
   assign o_instr_fault = valid && head.fault;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: cycle vector table plus scoreboard of accepted requests versus popped entries.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt = 1'b0;
   logic [31:0] i_imem_rdata = '0;
   logic        o_instr_valid;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic        o_instr_fault;
   logic        i_instr_ready = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = '0;

   int tests = 0;
   int fails = 0;

   fetch_entry_t sb [$];
   fetch_entry_t mon_e;
   logic [31:0]  exp_addr = RST_PC;
   logic [31:0]  acc_log [$];
   bit           log_en = 1'b0;

   typedef struct {
      logic        gnt;
      logic        ready;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   vec_t vecs [13];

   fetch_ctrl #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rdata  (i_imem_rdata),
      .o_instr_valid (o_instr_valid),
      .o_instr       (o_instr),
      .o_instr_pc    (o_instr_pc),
      .o_instr_fault (o_instr_fault),
      .i_instr_ready (i_instr_ready),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc)
   );

   always #5 i_clk = ~i_clk;

   // Memory model: each word holds its own address, returned one cycle after acceptance.
   always @(posedge i_clk) begin
      if (o_imem_req && i_imem_gnt) begin
         i_imem_rdata <= o_imem_addr;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic smp();
      @(negedge i_clk);
   endtask

   // Scoreboard monitor: accepted requests push expectations, pops compare, redirect/reset drop them.
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         sb.delete();
         exp_addr = RST_PC;
      end else begin
         if (o_instr_valid && i_instr_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_underflow: got pc %h expected no entry", o_instr_pc);
            end else begin
               mon_e = sb.pop_front();
               chk("sb_instr", o_instr, mon_e.instr);
               chk("sb_pc", o_instr_pc, mon_e.pc);
               chk("sb_fault", {31'd0, o_instr_fault}, {31'd0, mon_e.fault});
            end
         end
         if (o_imem_req && i_imem_gnt) begin
            chk("req_addr", o_imem_addr, exp_addr);
            sb.push_back(fetch_entry_t'{instr: exp_addr, pc: exp_addr, fault: 1'b0});
            if (log_en) acc_log.push_back(o_imem_addr);
            exp_addr = exp_addr + 32'd4;
         end
         if (i_redirect) begin
            chk("redir_noreq", {31'd0, o_imem_req}, 32'd0);
            sb.delete();
            exp_addr = i_redirect_pc;
            if (i_redirect_pc[1:0] != 2'b00) begin
               sb.push_back(fetch_entry_t'{instr: NOP, pc: i_redirect_pc, fault: 1'b1});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      //               gnt   rdy   req   addr           valid pc
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0104};
      for (int i = 4; i < 10; i++) begin
         vecs[i] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0108};
      end
      vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h0000_0110, 1'b1, 32'h0000_0108};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h0000_0114, 1'b1, 32'h0000_010C};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h0000_0118, 1'b1, 32'h0000_0110};

      // Reset state
      cyc();
      cyc();
      smp();
      chk("rst_req", {31'd0, o_imem_req}, 32'd0);
      chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
      chk("rst_instr", o_instr, 32'd0);
      chk("rst_pc", o_instr_pc, 32'd0);
      chk("rst_fault", {31'd0, o_instr_fault}, 32'd0);
      cyc();
      i_rst_n = 1'b1;

      // Fill, stream, back-pressure and release
      for (int i = 0; i < 13; i++) begin
         i_imem_gnt    = vecs[i].gnt;
         i_instr_ready = vecs[i].ready;
         smp();
         chk($sformatf("v%0d_req", i), {31'd0, o_imem_req}, {31'd0, vecs[i].req});
         if (vecs[i].req) chk($sformatf("v%0d_addr", i), o_imem_addr, vecs[i].addr);
         chk($sformatf("v%0d_valid", i), {31'd0, o_instr_valid}, {31'd0, vecs[i].valid});
         if (vecs[i].valid) begin
            chk($sformatf("v%0d_pc", i), o_instr_pc, vecs[i].pc);
            chk($sformatf("v%0d_instr", i), o_instr, vecs[i].pc);
         end
         cyc();
      end

      // Redirect one cycle after 0x118 accepted: that response is dropped
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h0000_0200;
      smp();
      cyc();
      i_redirect = 1'b0;
      smp();
      chk("rd_req", {31'd0, o_imem_req}, 32'd1);
      chk("rd_addr", o_imem_addr, 32'h0000_0200);
      chk("rd_valid1", {31'd0, o_instr_valid}, 32'd0);
      cyc();
      smp();
      chk("rd_valid2", {31'd0, o_instr_valid}, 32'd0);
      cyc();
      smp();
      chk("rd_valid3", {31'd0, o_instr_valid}, 32'd1);
      chk("rd_pc3", o_instr_pc, 32'h0000_0200);
      cyc();

      // Misaligned redirect produces a single fault entry and halts
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h0000_0202;
      smp();
      cyc();
      i_redirect = 1'b0;
      smp();
      chk("mis_req1", {31'd0, o_imem_req}, 32'd0);
      chk("mis_valid1", {31'd0, o_instr_valid}, 32'd0);
      cyc();
      smp();
      chk("mis_valid2", {31'd0, o_instr_valid}, 32'd1);
      chk("mis_instr", o_instr, 32'h0000_0013);
      chk("mis_pc", o_instr_pc, 32'h0000_0202);
      chk("mis_fault", {31'd0, o_instr_fault}, 32'd1);
      chk("mis_req2", {31'd0, o_imem_req}, 32'd0);
      cyc();
      for (int i = 0; i < 3; i++) begin
         smp();
         chk($sformatf("mis_idle%0d_req", i), {31'd0, o_imem_req}, 32'd0);
         chk($sformatf("mis_idle%0d_valid", i), {31'd0, o_instr_valid}, 32'd0);
         cyc();
      end
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h0000_0300;
      smp();
      cyc();
      i_redirect = 1'b0;
      smp();
      chk("resume_req", {31'd0, o_imem_req}, 32'd1);
      chk("resume_addr", o_imem_addr, 32'h0000_0300);
      cyc();

      // Address wrap with toggling grant and random ready
      acc_log.delete();
      log_en        = 1'b1;
      i_redirect    = 1'b1;
      i_redirect_pc = 32'hFFFF_FFF8;
      smp();
      cyc();
      i_redirect = 1'b0;
      for (int i = 0; i < 40; i++) begin
         i_imem_gnt    = (i % 2) == 0;
         i_instr_ready = 1'($urandom_range(0, 1));
         cyc();
      end
      log_en = 1'b0;
      chk("wrap_count", {31'd0, acc_log.size() >= 3}, 32'd1);
      chk("wrap_a0", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
      chk("wrap_a1", acc_log.size() > 1 ? acc_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      chk("wrap_a2", acc_log.size() > 2 ? acc_log[2] : 32'hDEAD_BEEF, 32'h0000_0000);
      i_imem_gnt    = 1'b1;
      i_instr_ready = 1'b1;
      repeat (6) cyc();

      // Reset mid-stream with a buffered entry and a response pending
      i_instr_ready = 1'b0;
      i_rst_n       = 1'b0;
      cyc();
      smp();
      chk("mrst_valid", {31'd0, o_instr_valid}, 32'd0);
      chk("mrst_req", {31'd0, o_imem_req}, 32'd0);
      chk("mrst_pc", o_instr_pc, 32'd0);
      cyc();
      i_rst_n       = 1'b1;
      i_instr_ready = 1'b1;
      smp();
      chk("mrst_req1", {31'd0, o_imem_req}, 32'd1);
      chk("mrst_addr1", o_imem_addr, RST_PC);
      chk("mrst_valid1", {31'd0, o_instr_valid}, 32'd0);
      cyc();
      smp();
      chk("mrst_valid2", {31'd0, o_instr_valid}, 32'd0);
      cyc();
      smp();
      chk("mrst_valid3", {31'd0, o_instr_valid}, 32'd1);
      chk("mrst_pc3", o_instr_pc, RST_PC);
      cyc();
      repeat (4) cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
